mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath. It is the issuing end of the ALU operation interface: it decodes opcode/funct, drives the 4-bit ALU operation code and operand selects, consumes the ALU zero flag, and sequences memory, register-file and PC writes. It sits between the instruction register and the datapath muxes and ALU, with a ready handshake to unified memory.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_multicycle_ctrl_alu_op_decode.sv | 26 ++
 rtl/mips_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle control path.
// Contents: FSM state encoding, opcode/funct constants, ALU operation codes,
// and the ALU operand-B / PC-source select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    StBoot     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecute  = 4'd7,
    StRwb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StAddiEx   = 4'd11,
    StAddiWb   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// R-type funct decoder.
// Ports: funct (IR[5:0]) in; alu_operation (4-bit ALU code) and funct_valid out.
// Unknown funct codes report funct_valid=0 and fall back to add.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       funct_valid
);

  always_comb begin
    alu_operation = ALU_ADD;
    funct_valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_AND:  alu_operation = ALU_AND;
      FN_OR:   alu_operation = ALU_OR;
      FN_SLT:  alu_operation = ALU_SLT;
      FN_NOR:  alu_operation = ALU_NOR;
      default: funct_valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Inputs: clk, rst_n (async, active-low), opcode/funct from IR, ALU zero flag,
// mem_ready handshake from unified memory.
// Outputs: ALU operation and operand selects, PC source/enable, memory
// address select and read/write requests, IR load, register-file controls,
// illegal_op and bus_error pulses, and the raw state for debug.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TCNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_operation,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        rtype_op;
  logic              funct_valid;
  logic              mem_state;
  logic              timeout;

  alu_op_decode u_alu_op_decode (
    .funct         (funct),
    .alu_operation (rtype_op),
    .funct_valid   (funct_valid)
  );

  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

  // Ready on the expiry cycle wins, so the timeout only fires with mem_ready low.
  assign timeout = (TIMEOUT_CYCLES != 0) && mem_state && !mem_ready &&
                   (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is zero whenever a memory state is entered, because every exit
  // (completion, timeout or any non-memory state) clears it.
  assign tcnt_d = (mem_state && !mem_ready && !timeout) ? tcnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_operation = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    pc_en         = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;

    case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = StFetch;
        end
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_d = StExecute;
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = StFetch;
        end
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = StFetch;
        end
      end
      StExecute: begin
        alu_src_a     = 1'b1;
        alu_operation = rtype_op;
        if (funct_valid) begin
          state_d = StRwb;
        end else begin
          illegal_op = 1'b1;
          state_d    = StFetch;
        end
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_en         = zero;
        state_d       = StFetch;
      end
      StJump: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StBoot;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl with TIMEOUT_CYCLES=4.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] S_BOOT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MADDR = 4'd3;
  localparam logic [3:0] S_MREAD = 4'd4, S_MWB = 4'd5, S_MWRITE = 4'd6, S_EXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10;
  localparam logic [3:0] S_AEX = 4'd11, S_AWB = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, mem_to_reg, illegal_op, bus_error;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl #(
    .TIMEOUT_CYCLES (4),
    .TCNT_W         (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_operation (alu_operation),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .pc_en         (pc_en),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] o;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // {alu, src_a, src_b, pc_source, pc_en, iord, mem_read, mem_write, ir_write,
  //  reg_dst, reg_write, mem_to_reg, illegal_op, bus_error}
  function automatic logic [18:0] o(input logic [3:0] alu, input logic sa,
                                    input logic [1:0] sb, input logic [1:0] ps,
                                    input logic pe, input logic io, input logic mr,
                                    input logic mw, input logic iw, input logic rd,
                                    input logic rw, input logic m2, input logic il,
                                    input logic be);
    return {alu, sa, sb, ps, pe, io, mr, mw, iw, rd, rw, m2, il, be};
  endfunction

  function automatic logic [18:0] dut_o();
    return {alu_operation, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read, mem_write,
            ir_write, reg_dst, reg_write, mem_to_reg, illegal_op, bus_error};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [3:0] st, input logic [18:0] eo);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.o = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] es, input logic [18:0] eo);
    n_vec++;
    if (state_dbg !== es || dut_o() !== eo) begin
      n_err++;
      $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
               nm, state_dbg, dut_o(), es, eo);
    end
    if (mem_read && mem_write) begin
      n_err++;
      $display("FAIL %s: mem_read and mem_write both high", nm);
    end
  endtask

  logic [18:0] boot_o, fetch1_o, fetch0_o, fetchto_o, dec_o, decill_o, rwb_o, addr_o;
  logic [18:0] mread_o, mwb_o, mwrite_o, mwriteto_o, jump_o, awb_o;

  initial begin
    boot_o     = o(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch1_o   = o(4'b0010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    fetch0_o   = o(4'b0010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    fetchto_o  = o(4'b0010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    dec_o      = o(4'b0010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    decill_o   = o(4'b0010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rwb_o      = o(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    addr_o     = o(4'b0010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mread_o    = o(4'b0010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    mwb_o      = o(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    mwrite_o   = o(4'b0010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    mwriteto_o = o(4'b0010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    jump_o     = o(4'b0010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    awb_o      = o(4'b0010, 0, 2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 1, 0, 0, 0);

    add(6'h00, 6'h00, 0, 0, S_BOOT, boot_o);
    // R-type slt, one fetch wait cycle first
    add(6'h00, 6'b101010, 0, 0, S_FETCH, fetch0_o);
    add(6'h00, 6'b101010, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b101010, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b101010, 0, 0, S_EXEC, o(4'b0111, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b101010, 0, 0, S_RWB, rwb_o);
    // R-type sub, nor, and, or
    add(6'h00, 6'b100010, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b100010, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b100010, 0, 0, S_EXEC, o(4'b0110, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b100010, 0, 0, S_RWB, rwb_o);
    add(6'h00, 6'b100111, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b100111, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b100111, 0, 0, S_EXEC, o(4'b1100, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b100111, 0, 0, S_RWB, rwb_o);
    add(6'h00, 6'b100100, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b100100, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b100100, 0, 0, S_EXEC, o(4'b0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b100100, 0, 0, S_RWB, rwb_o);
    add(6'h00, 6'b100101, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b100101, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b100101, 0, 0, S_EXEC, o(4'b0001, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b100101, 0, 0, S_RWB, rwb_o);
    // lw with three wait cycles
    add(6'b100011, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b100011, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b100011, 6'h00, 0, 0, S_MADDR, addr_o);
    add(6'b100011, 6'h00, 0, 0, S_MREAD, mread_o);
    add(6'b100011, 6'h00, 0, 0, S_MREAD, mread_o);
    add(6'b100011, 6'h00, 0, 0, S_MREAD, mread_o);
    add(6'b100011, 6'h00, 0, 1, S_MREAD, mread_o);
    add(6'b100011, 6'h00, 0, 0, S_MWB, mwb_o);
    // beq taken, then not taken
    add(6'b000100, 6'h00, 1, 1, S_FETCH, fetch1_o);
    add(6'b000100, 6'h00, 1, 0, S_DECODE, dec_o);
    add(6'b000100, 6'h00, 1, 0, S_BRANCH, o(4'b0110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'b000100, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b000100, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b000100, 6'h00, 0, 0, S_BRANCH, o(4'b0110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // j
    add(6'b000010, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b000010, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b000010, 6'h00, 0, 0, S_JUMP, jump_o);
    // addi
    add(6'b001000, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b001000, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b001000, 6'h00, 0, 0, S_AEX, addr_o);
    add(6'b001000, 6'h00, 0, 0, S_AWB, awb_o);
    // illegal opcode, then illegal funct
    add(6'b111111, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b111111, 6'h00, 0, 0, S_DECODE, decill_o);
    add(6'h00, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'h00, 0, 0, S_EXEC, o(4'b0010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // sw timing out in MEMWRITE
    add(6'b101011, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b101011, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b101011, 6'h00, 0, 0, S_MADDR, addr_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwriteto_o);
    // sw with ready arriving on the expiry cycle
    add(6'b101011, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'b101011, 6'h00, 0, 0, S_DECODE, dec_o);
    add(6'b101011, 6'h00, 0, 0, S_MADDR, addr_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 0, S_MWRITE, mwrite_o);
    add(6'b101011, 6'h00, 0, 1, S_MWRITE, mwrite_o);
    // fetch timeout retries in FETCH, then fetch succeeds
    add(6'h00, 6'h00, 0, 0, S_FETCH, fetch0_o);
    add(6'h00, 6'h00, 0, 0, S_FETCH, fetch0_o);
    add(6'h00, 6'h00, 0, 0, S_FETCH, fetch0_o);
    add(6'h00, 6'h00, 0, 0, S_FETCH, fetchto_o);
    add(6'h00, 6'h00, 0, 0, S_FETCH, fetch0_o);
    add(6'h00, 6'h00, 0, 1, S_FETCH, fetch1_o);
    add(6'h00, 6'b100000, 0, 0, S_DECODE, dec_o);
    add(6'h00, 6'b100000, 0, 0, S_EXEC, o(4'b0010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'h00, 6'b100000, 0, 0, S_RWB, rwb_o);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op;
      funct = vecs[i].fn;
      zero = vecs[i].z;
      mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].o);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a MEMREAD wait
    opcode = 6'b100011; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 check("pre_reset_memread", S_MREAD, mread_o);
    #1 rst_n = 1'b0;
    #1 check("async_reset", S_BOOT, boot_o);
    @(negedge clk); rst_n = 1'b1;
    #1 check("reset_release", S_BOOT, boot_o);
    @(negedge clk);
    #1 check("after_release", S_FETCH, fetch0_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
